// File: rtl/comp_path_sched.sv
// comp_path_sched: per-packet scheduler for the compression datapath.
//
// Ingress steers each AXI-Stream packet to the compression engine (c_*) or
// the bypass pipe (b_*), as chosen by s_comp_req on the first beat. The
// choice is held for the whole packet. Egress merges the compression return
// (rc_*) and bypass return (rb_*) toward DMA (m_*) in the original packet
// order, using a 1-bit route-order FIFO (1 = compression, 0 = bypass).
//
// Ports:
//   aclk, areset            clock; synchronous active-high reset
//   s_*, s_comp_req         ingress stream and per-packet route request
//   c_* / b_*               ingress copies toward the engine / bypass pipe
//   rc_* / rb_*             return streams from the engine / bypass pipe
//   m_*                     merged stream toward DMA
//   ord_count               packets routed in but not yet fully emitted
//   busy                    ingress mid-packet or packets still pending
//
// Optional build macro COMP_SCHED_PKT_CNT_EN adds per-path first-beat packet
// counters (cnt_comp, cnt_byp) with a synchronous clear input (cnt_clr).
//
// Ingress FSM:
//   state   | meaning
//   IDLE    | waiting for the first beat of a packet; route sampled here
//   COMP    | mid-packet, beats locked to the compression path
//   BYP     | mid-packet, beats locked to the bypass path

module comp_path_sched #(
  parameter int DATA_W    = 256,
  parameter int KEEP_W    = 32,
  parameter int ORD_DEPTH = 16,
  parameter int ORD_AW    = 4
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  input  logic              s_comp_req,
  output logic [DATA_W-1:0] c_tdata,
  output logic [KEEP_W-1:0] c_tkeep,
  output logic              c_tvalid,
  output logic              c_tlast,
  input  logic              c_tready,
  output logic [DATA_W-1:0] b_tdata,
  output logic [KEEP_W-1:0] b_tkeep,
  output logic              b_tvalid,
  output logic              b_tlast,
  input  logic              b_tready,
  input  logic [DATA_W-1:0] rc_tdata,
  input  logic [KEEP_W-1:0] rc_tkeep,
  input  logic              rc_tvalid,
  input  logic              rc_tlast,
  output logic              rc_tready,
  input  logic [DATA_W-1:0] rb_tdata,
  input  logic [KEEP_W-1:0] rb_tkeep,
  input  logic              rb_tvalid,
  input  logic              rb_tlast,
  output logic              rb_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [ORD_AW:0]   ord_count,
`ifdef COMP_SCHED_PKT_CNT_EN
  input  logic              cnt_clr,
  output logic [31:0]       cnt_comp,
  output logic [31:0]       cnt_byp,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_COMP, ST_BYP} state_e;

  localparam logic [ORD_AW:0] ORD_FULL_C = (ORD_AW+1)'(ORD_DEPTH);

  state_e              state_q, state_d;
  logic [ORD_DEPTH-1:0] ord_mem_q;
  logic [ORD_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ORD_AW:0]     cnt_q, cnt_d;
  logic                ord_full, ord_empty, head;
  logic                push, pop;

  assign ord_full  = (cnt_q == ORD_FULL_C);
  assign ord_empty = (cnt_q == '0);
  assign head      = ord_mem_q[rd_ptr_q];

  // Ingress payload fans out to both paths; only the valids are steered.
  assign c_tdata = s_tdata;
  assign c_tkeep = s_tkeep;
  assign c_tlast = s_tlast;
  assign b_tdata = s_tdata;
  assign b_tkeep = s_tkeep;
  assign b_tlast = s_tlast;

  always_comb begin
    state_d  = state_q;
    s_tready = 1'b0;
    c_tvalid = 1'b0;
    b_tvalid = 1'b0;
    push     = 1'b0;
    if (!areset) begin
      case (state_q)
        ST_IDLE: begin
          // Full only holds off the start of a new packet.
          s_tready = (s_comp_req ? c_tready : b_tready) && !ord_full;
          c_tvalid = s_comp_req && s_tvalid && !ord_full;
          b_tvalid = !s_comp_req && s_tvalid && !ord_full;
          if (s_tvalid && s_tready) begin
            push = 1'b1;
            if (!s_tlast) state_d = s_comp_req ? ST_COMP : ST_BYP;
          end
        end
        ST_COMP: begin
          s_tready = c_tready;
          c_tvalid = s_tvalid;
          if (s_tvalid && c_tready && s_tlast) state_d = ST_IDLE;
        end
        ST_BYP: begin
          s_tready = b_tready;
          b_tvalid = s_tvalid;
          if (s_tvalid && b_tready && s_tlast) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Egress: the registered head selects the source; no same-cycle bypass of
  // a freshly pushed entry.
  always_comb begin
    m_tdata   = head ? rc_tdata : rb_tdata;
    m_tkeep   = head ? rc_tkeep : rb_tkeep;
    m_tlast   = head ? rc_tlast : rb_tlast;
    m_tvalid  = 1'b0;
    rc_tready = 1'b0;
    rb_tready = 1'b0;
    if (!areset && !ord_empty) begin
      m_tvalid  = head ? rc_tvalid : rb_tvalid;
      rc_tready = head && m_tready;
      rb_tready = !head && m_tready;
    end
    pop = m_tvalid && m_tready && m_tlast;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (ORD_AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (ORD_AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + ORD_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ORD_AW'(1);
    end
  end

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge aclk) begin
    if (push) ord_mem_q[wr_ptr_q] <= s_comp_req;
  end

  assign ord_count = cnt_q;
  assign busy      = (state_q != ST_IDLE) || !ord_empty;

`ifdef COMP_SCHED_PKT_CNT_EN
  logic [31:0] cnt_comp_q, cnt_byp_q;

  always_ff @(posedge aclk) begin
    if (areset || cnt_clr) begin
      cnt_comp_q <= '0;
      cnt_byp_q  <= '0;
    end else if (push) begin
      if (s_comp_req) cnt_comp_q <= cnt_comp_q + 32'd1;
      else            cnt_byp_q  <= cnt_byp_q + 32'd1;
    end
  end

  assign cnt_comp = cnt_comp_q;
  assign cnt_byp  = cnt_byp_q;
`endif

endmodule

// File: tb/tb_comp_path_sched.sv
// Bench for comp_path_sched (ORD_DEPTH = 4). Loops c -> rc (extra cycle of
// delay) and b -> rb; checks every cycle against a packet-level model of
// routing, ordering and occupancy.
module tb_comp_path_sched;
  localparam int DW = 256;
  localparam int KW = 32;
  localparam int DEPTH = 4;
  localparam int AW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          req;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            t;
  } ret_t;

  logic aclk = 1'b0;
  logic areset;
  logic [DW-1:0] s_tdata, c_tdata, b_tdata, rc_tdata, rb_tdata, m_tdata;
  logic [KW-1:0] s_tkeep, c_tkeep, b_tkeep, rc_tkeep, rb_tkeep, m_tkeep;
  logic s_tvalid, s_tlast, s_tready, s_comp_req;
  logic c_tvalid, c_tlast, c_tready, b_tvalid, b_tlast, b_tready;
  logic rc_tvalid, rc_tlast, rc_tready, rb_tvalid, rb_tlast, rb_tready;
  logic m_tvalid, m_tlast, m_tready;
  logic [AW:0] ord_count;
  logic busy;
  logic cnt_clr;
`ifdef COMP_SCHED_PKT_CNT_EN
  logic [31:0] cnt_comp, cnt_byp;
`endif

  comp_path_sched #(.DATA_W(DW), .KEEP_W(KW), .ORD_DEPTH(DEPTH), .ORD_AW(AW)) dut (
    .aclk(aclk), .areset(areset),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .s_comp_req(s_comp_req),
    .c_tdata(c_tdata), .c_tkeep(c_tkeep), .c_tvalid(c_tvalid), .c_tlast(c_tlast),
    .c_tready(c_tready),
    .b_tdata(b_tdata), .b_tkeep(b_tkeep), .b_tvalid(b_tvalid), .b_tlast(b_tlast),
    .b_tready(b_tready),
    .rc_tdata(rc_tdata), .rc_tkeep(rc_tkeep), .rc_tvalid(rc_tvalid), .rc_tlast(rc_tlast),
    .rc_tready(rc_tready),
    .rb_tdata(rb_tdata), .rb_tkeep(rb_tkeep), .rb_tvalid(rb_tvalid), .rb_tlast(rb_tlast),
    .rb_tready(rb_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .ord_count(ord_count),
`ifdef COMP_SCHED_PKT_CNT_EN
    .cnt_clr(cnt_clr), .cnt_comp(cnt_comp), .cnt_byp(cnt_byp),
`endif
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  beat_t src_q[$];
  beat_t exp_q[$];
  ret_t  comp_ret[$];
  ret_t  byp_ret[$];
  bit    ordq[$];

  int cyc = 0;
  bit in_pkt = 0;
  bit cur_route = 0;
  int c_beats = 0, b_beats = 0, m_pkts = 0;
  int cnt_c_m = 0, cnt_b_m = 0;
  int sv_pct = 100, c_pct = 100, b_pct = 100, m_pct = 100;
  bit rc_en = 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit roll(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // toggle: non-first beats alternate the request; otherwise it is random.
  task automatic make_pkt(input int len, input bit req, input bit toggle);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = rand_data();
      b.keep = $urandom;
      b.last = (i == len - 1);
      if (i == 0)      b.req = req;
      else if (toggle) b.req = req ^ i[0];
      else             b.req = 1'($urandom_range(1));
      src_q.push_back(b);
    end
  endtask

  task automatic cycle();
    bit route, full, head, has_ord;
    bit e_str, e_cv, e_bv, e_mv, e_rcr, e_rbr;
    bit s_hs, c_hs, b_hs, m_hs, rc_hs, rb_hs, m_last, s_last, s_req;
    logic [DW-1:0] cd;
    logic [KW-1:0] ck;
    if (src_q.size() > 0) begin
      s_tdata    = src_q[0].data;
      s_tkeep    = src_q[0].keep;
      s_tlast    = src_q[0].last;
      s_comp_req = src_q[0].req;
      if (!s_tvalid) s_tvalid = roll(sv_pct);
    end else begin
      s_tvalid = 1'b0;
    end
    c_tready = roll(c_pct);
    b_tready = roll(b_pct);
    m_tready = roll(m_pct);
    if (rc_en && comp_ret.size() > 0 && comp_ret[0].t <= cyc) begin
      rc_tvalid = 1'b1;
      rc_tdata  = comp_ret[0].data;
      rc_tkeep  = comp_ret[0].keep;
      rc_tlast  = comp_ret[0].last;
    end else begin
      rc_tvalid = 1'b0;
    end
    if (byp_ret.size() > 0 && byp_ret[0].t <= cyc) begin
      rb_tvalid = 1'b1;
      rb_tdata  = byp_ret[0].data;
      rb_tkeep  = byp_ret[0].keep;
      rb_tlast  = byp_ret[0].last;
    end else begin
      rb_tvalid = 1'b0;
    end
    #2;
    has_ord = ordq.size() > 0;
    full    = ordq.size() >= DEPTH;
    head    = has_ord ? ordq[0] : 1'b0;
    route   = in_pkt ? cur_route : s_comp_req;
    e_str = !areset && (route ? c_tready : b_tready) && (in_pkt || !full);
    e_cv  = !areset && s_tvalid && route && (in_pkt || !full);
    e_bv  = !areset && s_tvalid && !route && (in_pkt || !full);
    e_mv  = !areset && has_ord && (head ? rc_tvalid : rb_tvalid);
    e_rcr = !areset && has_ord && head && m_tready;
    e_rbr = !areset && has_ord && !head && m_tready;
    chk("s_tready", s_tready, e_str);
    chk("c_tvalid", c_tvalid, e_cv);
    chk("b_tvalid", b_tvalid, e_bv);
    chk("m_tvalid", m_tvalid, e_mv);
    chk("rc_tready", rc_tready, e_rcr);
    chk("rb_tready", rb_tready, e_rbr);
    chk("ord_count", ord_count, ordq.size());
    chk("busy", busy, in_pkt || has_ord);
    chk("c_tdata", c_tdata, s_tdata);
    chk("b_tdata", b_tdata, s_tdata);
    if (e_mv && exp_q.size() > 0) begin
      chk("m_tdata", m_tdata, exp_q[0].data);
      chk("m_tkeep", m_tkeep, exp_q[0].keep);
      chk("m_tlast", m_tlast, exp_q[0].last);
    end
`ifdef COMP_SCHED_PKT_CNT_EN
    chk("cnt_comp", cnt_comp, cnt_c_m);
    chk("cnt_byp", cnt_byp, cnt_b_m);
`endif
    s_hs  = s_tvalid && s_tready;
    c_hs  = c_tvalid && c_tready;
    b_hs  = b_tvalid && b_tready;
    m_hs  = m_tvalid && m_tready;
    rc_hs = rc_tvalid && rc_tready;
    rb_hs = rb_tvalid && rb_tready;
    m_last = m_tlast;
    s_last = s_tlast;
    s_req  = s_comp_req;
    cd = s_tdata;
    ck = s_tkeep;
    @(posedge aclk);
    #1;
    cyc++;
    if (areset) begin
      ordq.delete();
      exp_q.delete();
      comp_ret.delete();
      byp_ret.delete();
      in_pkt  = 0;
      cnt_c_m = 0;
      cnt_b_m = 0;
    end else begin
      if (cnt_clr) begin
        cnt_c_m = 0;
        cnt_b_m = 0;
      end
      if (s_hs) begin
        if (!in_pkt) begin
          ordq.push_back(s_req);
          if (!cnt_clr) begin
            if (s_req) cnt_c_m++;
            else       cnt_b_m++;
          end
          if (!s_last) begin
            in_pkt    = 1;
            cur_route = s_req;
          end
        end else if (s_last) begin
          in_pkt = 0;
        end
        exp_q.push_back(src_q[0]);
        src_q.pop_front();
        s_tvalid = 1'b0;
      end
      if (c_hs) begin
        comp_ret.push_back('{data: cd, keep: ck, last: s_last, t: cyc + 1});
        c_beats++;
      end
      if (b_hs) begin
        byp_ret.push_back('{data: cd, keep: ck, last: s_last, t: cyc});
        b_beats++;
      end
      if (m_hs) begin
        if (exp_q.size() > 0) exp_q.pop_front();
        if (m_last) begin
          if (ordq.size() > 0) ordq.pop_front();
          m_pkts++;
        end
      end
      if (rc_hs && comp_ret.size() > 0) comp_ret.pop_front();
      if (rb_hs && byp_ret.size() > 0) byp_ret.pop_front();
    end
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((src_q.size() > 0 || ordq.size() > 0 || in_pkt) && n < max) begin
      cycle();
      n++;
    end
    chk({tag, "_drained"}, n < max, 1'b1);
    chk({tag, "_exp_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int c0, b0, m0, n;
    areset = 1'b1; cnt_clr = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tlast = 1'b1; s_comp_req = 1'b1; s_tvalid = 1'b1;
    c_tready = 1'b1; b_tready = 1'b1; m_tready = 1'b1;
    rc_tdata = '0; rc_tkeep = '0; rc_tlast = 1'b1; rc_tvalid = 1'b1;
    rb_tdata = '0; rb_tkeep = '0; rb_tlast = 1'b1; rb_tvalid = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    // Reset state with every upstream valid/ready asserted.
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_c_tvalid", c_tvalid, 1'b0);
    chk("rst_b_tvalid", b_tvalid, 1'b0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_rc_tready", rc_tready, 1'b0);
    chk("rst_rb_tready", rb_tready, 1'b0);
    chk("rst_ord_count", ord_count, 0);
    chk("rst_busy", busy, 1'b0);
    s_tvalid = 1'b0; rc_tvalid = 1'b0; rb_tvalid = 1'b0;
    areset = 1'b0;

    // Alternating routing: 4 x 3-beat packets, requests 1,0,1,0.
    c0 = c_beats; b0 = b_beats; m0 = m_pkts;
    make_pkt(3, 1, 0); make_pkt(3, 0, 0); make_pkt(3, 1, 0); make_pkt(3, 0, 0);
    drain("alt", 200);
    chk("alt_c_beats", c_beats - c0, 6);
    chk("alt_b_beats", b_beats - b0, 6);
    chk("alt_m_pkts", m_pkts - m0, 4);

    // Reordering hold: bypass return ready while the earlier compression
    // packet has not returned.
    rc_en = 0; m0 = m_pkts;
    make_pkt(2, 1, 0); make_pkt(2, 0, 0);
    repeat (10) cycle();
    chk("hold_rb_tready", rb_tready, 1'b0);
    chk("hold_m_tvalid", m_tvalid, 1'b0);
    chk("hold_rb_waiting", byp_ret.size(), 2);
    chk("hold_m_pkts", m_pkts - m0, 0);
    rc_en = 1;
    drain("hold", 200);
    chk("hold_m_pkts_after", m_pkts - m0, 2);

    // Full FIFO: 5 single-beat packets with egress stalled.
    m_pct = 0;
    for (int i = 0; i < 5; i++) make_pkt(1, 1'($urandom_range(1)), 0);
    repeat (8) cycle();
    chk("full_ord_count", ord_count, 4);
    chk("full_s_tready", s_tready, 1'b0);
    chk("full_pending", src_q.size(), 1);
    m_pct = 100;
    cycle();
    chk("full_pop_same_cycle", src_q.size(), 1);
    chk("full_after_pop", ord_count, 3);
    m_pct = 0;
    cycle();
    chk("full_next_cycle", src_q.size(), 0);
    chk("full_refilled", ord_count, 4);
    m_pct = 100;
    drain("full", 200);

    // Mid-packet lock: request toggles on every beat after a bypass start.
    c0 = c_beats; b0 = b_beats;
    make_pkt(8, 0, 1);
    drain("lock", 200);
    chk("lock_c_beats", c_beats - c0, 0);
    chk("lock_b_beats", b_beats - b0, 8);

    // Reset during beat 3 of 6; beat 3 then starts a new compression packet.
    make_pkt(6, 0, 0);
    src_q[2].req = 1'b1;
    n = 0;
    while (src_q.size() > 4 && n < 50) begin cycle(); n++; end
    chk("rstmid_reached", n < 50, 1'b1);
    areset = 1'b1;
    cycle();
    areset = 1'b0;
    chk("rstmid_ord_count", ord_count, 0);
    chk("rstmid_busy", busy, 1'b0);
    c0 = c_beats;
    drain("rstmid", 200);
    chk("rstmid_c_beats", c_beats - c0, 4);

    // Randomized traffic with random back-pressure on every interface.
    sv_pct = 80; c_pct = 70; b_pct = 70; m_pct = 60;
    for (int i = 0; i < 40; i++) make_pkt(int'($urandom_range(5, 1)), 1'($urandom_range(1)), 0);
    drain("rand", 5000);
    sv_pct = 100; c_pct = 100; b_pct = 100; m_pct = 100;

`ifdef COMP_SCHED_PKT_CNT_EN
    areset = 1'b1;
    cycle();
    areset = 1'b0;
    make_pkt(2, 1, 0); make_pkt(2, 0, 0); make_pkt(2, 1, 0); make_pkt(2, 1, 0); make_pkt(2, 0, 0);
    drain("cnt", 300);
    chk("cnt_comp_3", cnt_comp, 3);
    chk("cnt_byp_2", cnt_byp, 2);
    make_pkt(1, 1, 0);
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    chk("cnt_clr_hs", src_q.size(), 0);
    chk("cnt_clr_comp", cnt_comp, 0);
    chk("cnt_clr_byp", cnt_byp, 0);
    drain("cnt_clr", 100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
